unit_risk_seq: RTL and testbench
================================

// Module: unit_risk_seq
// PURPOSE
//  Sequential, parametrised hazard unit between IF/ID and ID/EX: detects load-use and JALR-on-load hazards
//  (register 0 never hazards), stretches the branch flush over FLUSH_CYCLES, latches HALT as a sticky state,
//  gates everything with a debug step enable, and counts stall/flush cycles for the debug unit.
// PARAMETERS
//  BITS_REGS     5   register index width
//  FLUSH_CYCLES  1   cycles o_flush_latch stays high per i_EXMEM_flush (>=1; 1 = single-cycle flush)
//  CNT_BITS      16  width of the saturating stall/flush counters
// PORTS
//  i_clk             in   1          clock; all state updates on rising edge
//  i_reset           in   1          synchronous, active-high reset
//  i_enable          in   1          debug run/step enable; 0 freezes pipeline and this block
//  i_EXMEM_flush     in   1          branch taken in EX/MEM (same select as the IF PC mux)
//  i_IDEX_mem_read   in   1          instruction in ID/EX is a load
//  i_EXMEM_mem_read  in   1          instruction in EX/MEM is a load
//  i_JALR            in   1          instruction in IF/ID is JALR/JR
//  i_HALT            in   1          instruction in IF/ID is HALT
//  i_IFID_uses_rt    in   1          instruction in IF/ID reads rt as a source
//  i_IDEX_rt         in   BITS_REGS  load destination in ID/EX
//  i_EXMEM_rt        in   BITS_REGS  load destination in EX/MEM
//  i_IFID_rs         in   BITS_REGS  source rs in IF/ID
//  i_IFID_rt         in   BITS_REGS  source rt in IF/ID
//  o_risk_mux        out  1          1 = inject bubble (zero control) into ID/EX
//  o_pc_write        out  1          PC load enable
//  o_IFID_write      out  1          IF/ID latch enable
//  o_flush_latch     out  1          flush IF/ID and ID/EX latches
//  o_halted          out  1          HALT committed; pipeline frozen
//  o_stall_count     out  CNT_BITS   cycles with o_risk_mux=1, saturating
//  o_flush_count     out  CNT_BITS   cycles with o_flush_latch=1, saturating
// BEHAVIOUR
//  Hazard terms (combinational):
//   LU = i_IDEX_mem_read & i_IDEX_rt!=0 & (i_IDEX_rt==i_IFID_rs | (i_IFID_uses_rt & i_IDEX_rt==i_IFID_rt))
//   JL = i_JALR & i_EXMEM_mem_read & i_EXMEM_rt!=0 & i_EXMEM_rt==i_IFID_rs;   HZ = LU | JL
//  States: RUN, FLUSH, HALT. Reset -> RUN; flush counter=0; both counters=0.
//  While i_reset=1: risk_mux=0, pc_write=0, IFID_write=0, flush_latch=0, halted=0.
//  i_enable=0 (any state): risk_mux=0, pc_write=0, IFID_write=0, flush_latch=0; state, flush counter,
//   counters hold; o_halted keeps its value.
//  RUN, priority flush > hazard > halt > normal:
//   i_EXMEM_flush: flush_latch=1, pc_write=1, IFID_write=1, risk_mux=0; if FLUSH_CYCLES>1 -> FLUSH with
//    remaining=FLUSH_CYCLES-1, else stay RUN. Concurrent HZ/HALT ignored (wrong path).
//   HZ: risk_mux=1, pc_write=0, IFID_write=0; stay RUN (re-evaluated every cycle, no extra latency).
//   i_HALT: pc_write=0, IFID_write=1, risk_mux=0; -> HALT next cycle.
//   else: pc_write=1, IFID_write=1, risk_mux=0.
//  FLUSH: flush_latch=1, pc_write=1, IFID_write=1, risk_mux=0; HZ and HALT ignored.
//   i_EXMEM_flush reloads remaining=FLUSH_CYCLES-1; else remaining-1; remaining reaching 0 -> RUN.
//  HALT: o_halted=1, pc_write=0, IFID_write=0, risk_mux=0; exits only on reset, except i_EXMEM_flush
//   (halt was speculative): flush_latch=1, pc_write=1, IFID_write=1, o_halted=0 that cycle, then
//   FLUSH (FLUSH_CYCLES>1) or RUN.
//  Counters increment by 1 on each enabled cycle with the respective output high; hold at 2^CNT_BITS-1.
//  All outputs are combinational from state + inputs; zero added latency.
// TESTING
//  1 Load r5 in ID/EX, IF/ID rs=5 -> risk_mux=1, pc_write=0, IFID_write=0 one cycle; stall_count 0->1.
//  2 Load r0 in ID/EX, IF/ID rs=0 -> no stall; load r7, rt=7, uses_rt=0 -> no stall.
//  3 JALR rs=9, EX/MEM load rt=9 -> stall; same with i_JALR=0 -> no stall.
//  4 FLUSH_CYCLES=3: flush pulse 1 cycle -> flush_latch high 3 cycles, HZ ignored; second flush in
//    cycle 2 -> 3 more cycles from there; flush_count=4.
//  5 HALT in IF/ID -> pc_write=0 cycle t, o_halted=1 from t+1 held 20 cycles; flush at t+1 -> halted=0,
//    flush_latch=1, then RUN; reset -> halted=0, counters=0.
//  6 i_enable=0 mid-FLUSH and mid-stall -> all enables 0, state and counters frozen; resume continues.

Source files
------------

// File: rtl/unit_risk_seq.sv
// Hazard unit between IF/ID and ID/EX: load-use / JALR-on-load stalls, stretched
// branch flush, sticky HALT, debug enable gating and saturating stall/flush counters.
module unit_risk_seq #(
  parameter int BITS_REGS    = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_BITS     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_EXMEM_flush,
  input  logic                 i_IDEX_mem_read,
  input  logic                 i_EXMEM_mem_read,
  input  logic                 i_JALR,
  input  logic                 i_HALT,
  input  logic                 i_IFID_uses_rt,
  input  logic [BITS_REGS-1:0] i_IDEX_rt,
  input  logic [BITS_REGS-1:0] i_EXMEM_rt,
  input  logic [BITS_REGS-1:0] i_IFID_rs,
  input  logic [BITS_REGS-1:0] i_IFID_rt,
  output logic                 o_risk_mux,
  output logic                 o_pc_write,
  output logic                 o_IFID_write,
  output logic                 o_flush_latch,
  output logic                 o_halted,
  output logic [CNT_BITS-1:0]  o_stall_count,
  output logic [CNT_BITS-1:0]  o_flush_count
);

  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

  state_t           state, state_nx;
  logic [REM_W-1:0] rem, rem_nx;
  logic             lu, jl, hz;

  always_comb begin
    lu = i_IDEX_mem_read && (i_IDEX_rt != '0) &&
         ((i_IDEX_rt == i_IFID_rs) || (i_IFID_uses_rt && (i_IDEX_rt == i_IFID_rt)));
    jl = i_JALR && i_EXMEM_mem_read && (i_EXMEM_rt != '0) && (i_EXMEM_rt == i_IFID_rs);
    hz = lu || jl;
  end

  always_comb begin
    o_risk_mux    = 1'b0;
    o_pc_write    = 1'b0;
    o_IFID_write  = 1'b0;
    o_flush_latch = 1'b0;
    o_halted      = (state == ST_HALT);
    state_nx      = state;
    rem_nx        = rem;
    if (i_reset) begin
      o_halted = 1'b0;
    end else if (i_enable) begin
      case (state)
        ST_RUN: begin
          if (i_EXMEM_flush) begin
            o_flush_latch = 1'b1;
            o_pc_write    = 1'b1;
            o_IFID_write  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nx = ST_FLUSH;
              rem_nx   = REM_RELOAD;
            end
          end else if (hz) begin
            o_risk_mux = 1'b1;
          end else if (i_HALT) begin
            o_IFID_write = 1'b1;
            state_nx     = ST_HALT;
          end else begin
            o_pc_write   = 1'b1;
            o_IFID_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          o_flush_latch = 1'b1;
          o_pc_write    = 1'b1;
          o_IFID_write  = 1'b1;
          if (i_EXMEM_flush) begin
            rem_nx = REM_RELOAD;
          end else if (rem <= REM_W'(1)) begin
            rem_nx   = '0;
            state_nx = ST_RUN;
          end else begin
            rem_nx = rem - REM_W'(1);
          end
        end
        ST_HALT: begin
          // A taken branch means the HALT was fetched on a wrong path: release it.
          if (i_EXMEM_flush) begin
            o_flush_latch = 1'b1;
            o_pc_write    = 1'b1;
            o_IFID_write  = 1'b1;
            o_halted      = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state_nx = ST_FLUSH;
              rem_nx   = REM_RELOAD;
            end else begin
              state_nx = ST_RUN;
            end
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_RUN;
      rem           <= '0;
      o_stall_count <= '0;
      o_flush_count <= '0;
    end else if (i_enable) begin
      state <= state_nx;
      rem   <= rem_nx;
      if (o_risk_mux && (o_stall_count != '1))
        o_stall_count <= o_stall_count + CNT_BITS'(1);
      if (o_flush_latch && (o_flush_count != '1))
        o_flush_count <= o_flush_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_unit_risk_seq.sv
// Scoreboard bench for unit_risk_seq (FLUSH_CYCLES=3, 3-bit counters to reach saturation).
module tb_unit_risk_seq;

  localparam int BR = 5;
  localparam int CB = 3;

  // ctrl = {risk_mux, pc_write, IFID_write, flush_latch, halted}
  localparam logic [4:0] C_ZERO = 5'b00000;
  localparam logic [4:0] C_NORM = 5'b01100;
  localparam logic [4:0] C_STAL = 5'b10000;
  localparam logic [4:0] C_FLSH = 5'b01110;
  localparam logic [4:0] C_HLTI = 5'b00100;
  localparam logic [4:0] C_HLTD = 5'b00001;

  typedef struct packed {
    logic [4:0]    ctrl;
    logic [CB-1:0] sc;
    logic [CB-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, fl, idex_mr, exmem_mr, jalr, halt, uses_rt;
  logic [BR-1:0] idex_rt, exmem_rt, rs, rt;
  logic risk_mux, pc_write, ifid_write, flush_latch, halted;
  logic [CB-1:0] stall_count, flush_count;

  exp_t  q[$];
  string names[$];
  int    tot_cnt = 0;
  int    pass_cnt = 0;

  always #5 clk = ~clk;

  unit_risk_seq #(.BITS_REGS(BR), .FLUSH_CYCLES(3), .CNT_BITS(CB)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_EXMEM_flush(fl),
    .i_IDEX_mem_read(idex_mr), .i_EXMEM_mem_read(exmem_mr), .i_JALR(jalr),
    .i_HALT(halt), .i_IFID_uses_rt(uses_rt), .i_IDEX_rt(idex_rt),
    .i_EXMEM_rt(exmem_rt), .i_IFID_rs(rs), .i_IFID_rt(rt),
    .o_risk_mux(risk_mux), .o_pc_write(pc_write), .o_IFID_write(ifid_write),
    .o_flush_latch(flush_latch), .o_halted(halted),
    .o_stall_count(stall_count), .o_flush_count(flush_count)
  );

  exp_t       e;
  string      nm;
  logic [4:0] act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      nm  = names.pop_front();
      act = {risk_mux, pc_write, ifid_write, flush_latch, halted};
      tot_cnt++;
      if (act === e.ctrl) pass_cnt++;
      else $display("FAIL %s ctrl: got %b expected %b", nm, act, e.ctrl);
      tot_cnt++;
      if (stall_count === e.sc) pass_cnt++;
      else $display("FAIL %s stall_count: got %0d expected %0d", nm, stall_count, e.sc);
      tot_cnt++;
      if (flush_count === e.fc) pass_cnt++;
      else $display("FAIL %s flush_count: got %0d expected %0d", nm, flush_count, e.fc);
    end
  end

  task automatic clr();
    rst = 1'b0; en = 1'b1; fl = 1'b0; idex_mr = 1'b0; exmem_mr = 1'b0;
    jalr = 1'b0; halt = 1'b0; uses_rt = 1'b0;
    idex_rt = '0; exmem_rt = '0; rs = '0; rt = '0;
  endtask

  task automatic load_use();
    idex_mr = 1'b1; idex_rt = 5'd5; rs = 5'd5;
  endtask

  task automatic chk(input logic [4:0] c, input int s, input int f, input string n);
    q.push_back({c, CB'(s), CB'(f)});
    names.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(C_ZERO, 0, 0, "reset_a");
    chk(C_ZERO, 0, 0, "reset_b");
    rst = 1'b0;
    chk(C_NORM, 0, 0, "run_idle");

    // load-use and JALR-on-load detection
    load_use();                                        chk(C_STAL, 0, 0, "lu_rs");
    clr();                                             chk(C_NORM, 1, 0, "after_lu");
    idex_mr = 1; idex_rt = 6; uses_rt = 1; rt = 6;     chk(C_STAL, 1, 0, "lu_rt");
    clr(); idex_mr = 1; idex_rt = 0; rs = 0;           chk(C_NORM, 2, 0, "lu_r0");
    clr(); idex_mr = 1; idex_rt = 7; rt = 7; rs = 3;   chk(C_NORM, 2, 0, "lu_rt_unused");
    clr(); jalr = 1; exmem_mr = 1; exmem_rt = 9; rs = 9; chk(C_STAL, 2, 0, "jalr_load");
    jalr = 0;                                          chk(C_NORM, 3, 0, "no_jalr");
    jalr = 1; exmem_rt = 0; rs = 0;                    chk(C_NORM, 3, 0, "jalr_r0");

    // stall counter saturates at 7
    clr(); load_use();
    for (int i = 0; i < 6; i++) chk(C_STAL, (i < 4) ? 3 + i : 7, 0, "stall_sat");
    clr();                                             chk(C_NORM, 7, 0, "sat_hold");
    rst = 1;                                           chk(C_ZERO, 7, 0, "rst_a");
    rst = 0;                                           chk(C_NORM, 0, 0, "rst_clear_a");

    // stretched flush ignores hazards, then hazard acts in RUN
    fl = 1; load_use();                                chk(C_FLSH, 0, 0, "fl0_hz");
    fl = 0;                                            chk(C_FLSH, 0, 1, "fl1_hz");
    chk(C_FLSH, 0, 2, "fl2_hz");
    chk(C_STAL, 0, 3, "fl_done_hz");
    clr();                                             chk(C_NORM, 1, 3, "fl_run");
    // re-flush in the second flush cycle restarts the window
    fl = 1;                                            chk(C_FLSH, 1, 3, "refl0");
    chk(C_FLSH, 1, 4, "refl1");
    fl = 0;                                            chk(C_FLSH, 1, 5, "refl2");
    chk(C_FLSH, 1, 6, "refl3");
    chk(C_NORM, 1, 7, "refl_done");
    rst = 1;                                           chk(C_ZERO, 1, 7, "rst_b");
    rst = 0;                                           chk(C_NORM, 0, 0, "rst_clear_b");

    // enable freeze mid-flush and mid-stall
    fl = 1;                                            chk(C_FLSH, 0, 0, "en_fl0");
    clr(); load_use(); en = 0;                         chk(C_ZERO, 0, 1, "en_off_fl_a");
    chk(C_ZERO, 0, 1, "en_off_fl_b");
    clr();                                             chk(C_FLSH, 0, 1, "en_fl1");
    chk(C_FLSH, 0, 2, "en_fl2");
    chk(C_NORM, 0, 3, "en_fl_done");
    load_use();                                        chk(C_STAL, 0, 3, "en_st0");
    en = 0;                                            chk(C_ZERO, 1, 3, "en_off_st_a");
    chk(C_ZERO, 1, 3, "en_off_st_b");
    en = 1;                                            chk(C_STAL, 1, 3, "en_st1");
    clr();                                             chk(C_NORM, 2, 3, "en_st_done");

    // HALT is sticky, released by flush
    halt = 1;                                          chk(C_HLTI, 2, 3, "halt_issue");
    clr();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) load_use();
      if (i == 6) clr();
      if (i == 10) en = 0;
      if (i == 11) en = 1;
      chk(C_HLTD, 2, 3, "halt_hold");
    end
    fl = 1;                                            chk(C_FLSH, 2, 3, "halt_flush");
    fl = 0;                                            chk(C_FLSH, 2, 4, "halt_fl1");
    chk(C_FLSH, 2, 5, "halt_fl2");
    chk(C_NORM, 2, 6, "halt_fl_run");
    halt = 1; load_use();                              chk(C_STAL, 2, 6, "hz_over_halt");
    clr();                                             chk(C_NORM, 3, 6, "hz_over_halt_run");
    halt = 1; fl = 1;                                  chk(C_FLSH, 3, 6, "fl_over_halt");
    clr();                                             chk(C_FLSH, 3, 7, "fl_sat_a");
    chk(C_FLSH, 3, 7, "fl_sat_b");
    chk(C_NORM, 3, 7, "fl_sat_run");
    halt = 1;                                          chk(C_HLTI, 3, 7, "halt2_issue");
    clr();                                             chk(C_HLTD, 3, 7, "halt2_hold");
    rst = 1;                                           chk(C_ZERO, 3, 7, "halt_rst");
    rst = 0;                                           chk(C_NORM, 0, 0, "halt_rst_run");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tot_cnt++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
